csr_ctrl: RTL and testbench



---
 rtl/csr_ctrl_pkg.sv | 34 +++
 rtl/csr_rmw.sv | 33 +++
 rtl/csr_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_csr_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_ctrl_pkg.sv
// Shared constants and types for the CSR sequencing controller.
// Machine CSR addresses, op encodings, mstatus bit positions, FSM states.
package csr_ctrl_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam int MIE_BIT  = 3;
   localparam int MPIE_BIT = 7;

   typedef enum logic [1:0] {
      OP_RW  = 2'b00,
      OP_RS  = 2'b01,
      OP_RC  = 2'b10,
      OP_RSV = 2'b11
   } csr_op_e;

   typedef enum logic [3:0] {
      IDLE,
      I_RD,
      I_WR,
      T_TVEC,
      T_EPC,
      T_CAUSE,
      T_SRD,
      T_SWR,
      M_EPC,
      M_SRD,
      M_SWR
   } state_e;

endpackage

// File: rtl/csr_rmw.sv
// Read-modify-write datapath for CSRRW/CSRRS/CSRRC.
// Reserved op acts as CSRRW with the write suppressed.
module csr_rmw
   import csr_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  csr_op_e         op_i,
   input  logic [XLEN-1:0] old_i,
   input  logic [XLEN-1:0] src_i,
   input  logic            nowr_i,
   output logic [XLEN-1:0] wdata_o,
   output logic            we_o
);

   always_comb begin
      wdata_o = src_i;
      we_o    = 1'b0;
      unique case (op_i)
         OP_RW: we_o = 1'b1;
         OP_RS: begin
            wdata_o = old_i | src_i;
            we_o    = !nowr_i;
         end
         OP_RC: begin
            wdata_o = old_i & ~src_i;
            we_o    = !nowr_i;
         end
         default: we_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/csr_ctrl.sv
// Sequences CSR instructions, trap entry and MRET over a single
// CSR file port pair; one CSR access per cycle.
module csr_ctrl
   import csr_ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 12
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              instr_valid,
   input  logic [1:0]        instr_op,
   input  logic [CSR_AW-1:0] instr_addr,
   input  logic [XLEN-1:0]   instr_src,
   input  logic              instr_nowr,
   output logic              instr_done,
   output logic [XLEN-1:0]   instr_rdata,
   input  logic              trap_req,
   input  logic [XLEN-1:0]   trap_pc,
   input  logic [XLEN-1:0]   trap_cause,
   output logic              trap_ack,
   input  logic              mret_req,
   output logic              redirect_valid,
   output logic [XLEN-1:0]   redirect_pc,
   output logic              busy,
   output logic              csr_we,
   output logic [CSR_AW-1:0] csr_waddr,
   output logic [XLEN-1:0]   csr_wdata,
   output logic              csr_re,
   output logic [CSR_AW-1:0] csr_raddr,
   input  logic [XLEN-1:0]   csr_rdata
);

   localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(CSR_MSTATUS);
   localparam logic [CSR_AW-1:0] A_MTVEC   = CSR_AW'(CSR_MTVEC);
   localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(CSR_MEPC);
   localparam logic [CSR_AW-1:0] A_MCAUSE  = CSR_AW'(CSR_MCAUSE);

   state_e            state_q, state_d;
   csr_op_e           op_q, op_d;
   logic [CSR_AW-1:0] addr_q, addr_d;
   logic [XLEN-1:0]   src_q, src_d;
   logic              nowr_q, nowr_d;
   logic [XLEN-1:0]   old_q, old_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   cause_q, cause_d;
   logic [XLEN-1:0]   tvec_q, tvec_d;
   logic [XLEN-1:0]   st_q, st_d;
   logic [XLEN-1:0]   epc_q, epc_d;

   logic [XLEN-1:0]   rmw_wdata;
   logic              rmw_we;
   logic [XLEN-1:0]   st_trap, st_mret;

   csr_rmw #(.XLEN(XLEN)) u_rmw (
      .op_i    (op_q),
      .old_i   (old_q),
      .src_i   (src_q),
      .nowr_i  (nowr_q),
      .wdata_o (rmw_wdata),
      .we_o    (rmw_we)
   );

   always_comb begin
      st_trap           = st_q;
      st_trap[MPIE_BIT] = st_q[MIE_BIT];
      st_trap[MIE_BIT]  = 1'b0;
      st_mret           = st_q;
      st_mret[MIE_BIT]  = st_q[MPIE_BIT];
      st_mret[MPIE_BIT] = 1'b1;
   end

   assign busy        = (state_q != IDLE);
   assign instr_rdata = old_q;

   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      addr_d         = addr_q;
      src_d          = src_q;
      nowr_d         = nowr_q;
      old_d          = old_q;
      pc_d           = pc_q;
      cause_d        = cause_q;
      tvec_d         = tvec_q;
      st_d           = st_q;
      epc_d          = epc_q;
      csr_we         = 1'b0;
      csr_waddr      = '0;
      csr_wdata      = '0;
      csr_re         = 1'b0;
      csr_raddr      = '0;
      instr_done     = 1'b0;
      trap_ack       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      if (rdy_in) begin
         unique case (state_q)
            IDLE: begin
               if (trap_req) begin
                  trap_ack = 1'b1;
                  pc_d     = trap_pc;
                  cause_d  = trap_cause;
                  state_d  = T_TVEC;
               end else if (mret_req) begin
                  state_d = M_EPC;
               end else if (instr_valid) begin
                  op_d    = csr_op_e'(instr_op);
                  addr_d  = instr_addr;
                  src_d   = instr_src;
                  nowr_d  = instr_nowr;
                  state_d = I_RD;
               end
            end
            I_RD: begin
               csr_re    = 1'b1;
               csr_raddr = addr_q;
               old_d     = csr_rdata;
               state_d   = I_WR;
            end
            I_WR: begin
               csr_we     = rmw_we;
               csr_waddr  = addr_q;
               csr_wdata  = rmw_wdata;
               instr_done = 1'b1;
               state_d    = IDLE;
            end
            T_TVEC: begin
               csr_re    = 1'b1;
               csr_raddr = A_MTVEC;
               tvec_d    = csr_rdata;
               state_d   = T_EPC;
            end
            T_EPC: begin
               csr_we    = 1'b1;
               csr_waddr = A_MEPC;
               csr_wdata = pc_q;
               state_d   = T_CAUSE;
            end
            T_CAUSE: begin
               csr_we    = 1'b1;
               csr_waddr = A_MCAUSE;
               csr_wdata = cause_q;
               state_d   = T_SRD;
            end
            T_SRD: begin
               csr_re    = 1'b1;
               csr_raddr = A_MSTATUS;
               st_d      = csr_rdata;
               state_d   = T_SWR;
            end
            T_SWR: begin
               csr_we         = 1'b1;
               csr_waddr      = A_MSTATUS;
               csr_wdata      = st_trap;
               redirect_valid = 1'b1;
               redirect_pc    = {tvec_q[XLEN-1:2], 2'b00};
               state_d        = IDLE;
            end
            M_EPC: begin
               csr_re    = 1'b1;
               csr_raddr = A_MEPC;
               epc_d     = csr_rdata;
               state_d   = M_SRD;
            end
            M_SRD: begin
               csr_re    = 1'b1;
               csr_raddr = A_MSTATUS;
               st_d      = csr_rdata;
               state_d   = M_SWR;
            end
            M_SWR: begin
               csr_we         = 1'b1;
               csr_waddr      = A_MSTATUS;
               csr_wdata      = st_mret;
               redirect_valid = 1'b1;
               redirect_pc    = epc_q;
               state_d        = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Stalling on rdy_in simply skips the register update.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= IDLE;
         op_q    <= OP_RW;
         addr_q  <= '0;
         src_q   <= '0;
         nowr_q  <= 1'b0;
         old_q   <= '0;
         pc_q    <= '0;
         cause_q <= '0;
         tvec_q  <= '0;
         st_q    <= '0;
         epc_q   <= '0;
      end else if (rdy_in) begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         src_q   <= src_d;
         nowr_q  <= nowr_d;
         old_q   <= old_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
         tvec_q  <= tvec_d;
         st_q    <= st_d;
         epc_q   <= epc_d;
      end
   end

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed bench for csr_ctrl with a behavioural CSR file.
module tb_csr_ctrl;

   logic        clk = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        instr_valid;
   logic [1:0]  instr_op;
   logic [11:0] instr_addr;
   logic [31:0] instr_src;
   logic        instr_nowr;
   logic        instr_done;
   logic [31:0] instr_rdata;
   logic        trap_req;
   logic [31:0] trap_pc;
   logic [31:0] trap_cause;
   logic        trap_ack;
   logic        mret_req;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;
   logic        csr_we;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic        csr_re;
   logic [11:0] csr_raddr;
   logic [31:0] csr_rdata;

   logic [31:0] mem [0:4095];
   logic        bd_we = 1'b0;
   logic [11:0] bd_addr = '0;
   logic [31:0] bd_data = '0;
   int          ovl = 0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   csr_ctrl dut (
      .clk_in         (clk),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .instr_valid    (instr_valid),
      .instr_op       (instr_op),
      .instr_addr     (instr_addr),
      .instr_src      (instr_src),
      .instr_nowr     (instr_nowr),
      .instr_done     (instr_done),
      .instr_rdata    (instr_rdata),
      .trap_req       (trap_req),
      .trap_pc        (trap_pc),
      .trap_cause     (trap_cause),
      .trap_ack       (trap_ack),
      .mret_req       (mret_req),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .busy           (busy),
      .csr_we         (csr_we),
      .csr_waddr      (csr_waddr),
      .csr_wdata      (csr_wdata),
      .csr_re         (csr_re),
      .csr_raddr      (csr_raddr),
      .csr_rdata      (csr_rdata)
   );

   assign csr_rdata = mem[csr_raddr];

   always @(posedge clk) begin
      if (csr_we) mem[csr_waddr] <= csr_wdata;
      else if (bd_we) mem[bd_addr] <= bd_data;
      if (csr_we && csr_re) ovl <= ovl + 1;
   end

   typedef struct {
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] src;
      logic        nowr;
      logic [31:0] init;
      logic [31:0] exp_rd;
      logic [31:0] exp_new;
      int          exp_we;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic poke(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic do_instr(input vec_t v, input int k);
      int n;
      int wes;
      string nm;
      nm = $sformatf("vec%0d", k);
      poke(v.addr, v.init);
      @(negedge clk);
      instr_valid = 1'b1; instr_op = v.op; instr_addr = v.addr;
      instr_src = v.src; instr_nowr = v.nowr;
      n = 0; wes = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (csr_we) wes++;
         if (instr_done) begin n = i; break; end
      end
      chk({nm, " latency"}, n, 2);
      chk({nm, " rdata"}, instr_rdata, v.exp_rd);
      chk({nm, " we_count"}, wes, v.exp_we);
      instr_valid = 1'b0;
      @(posedge clk); #1;
      chk({nm, " csr_value"}, mem[v.addr], v.exp_new);
      chk({nm, " idle"}, {31'd0, busy}, 0);
   endtask

   initial begin
      int n, m;
      logic [31:0] rpc;
      logic [31:0] rd;
      rst_in = 1'b1; rdy_in = 1'b1;
      instr_valid = 0; instr_op = 0; instr_addr = 0;
      instr_src = 0; instr_nowr = 0;
      trap_req = 0; trap_pc = 0; trap_cause = 0; mret_req = 0;
      #2 rst_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", {31'd0, busy}, 0);
      chk("rst done", {31'd0, instr_done}, 0);
      chk("rst we", {31'd0, csr_we}, 0);
      chk("rst re", {31'd0, csr_re}, 0);
      chk("rst ack", {31'd0, trap_ack}, 0);
      chk("rst redirect", {31'd0, redirect_valid}, 0);
      chk("rst rdata", instr_rdata, 0);
      @(negedge clk) rst_in = 1'b1;

      vecs[0] = '{2'b01, 12'h300, 32'h80, 1'b0, 32'h8, 32'h8, 32'h88, 1};
      vecs[1] = '{2'b10, 12'h305, 32'h3, 1'b1, 32'h1003, 32'h1003, 32'h1003, 0};
      vecs[2] = '{2'b00, 12'h340, 32'h1234, 1'b1, 32'hdead, 32'hdead, 32'h1234, 1};
      vecs[3] = '{2'b10, 12'h340, 32'h0f, 1'b0, 32'hff, 32'hff, 32'hf0, 1};
      vecs[4] = '{2'b11, 12'h341, 32'haa, 1'b0, 32'h55, 32'h55, 32'h55, 0};
      vecs[5] = '{2'b01, 12'h342, 32'h8, 1'b1, 32'h7, 32'h7, 32'h7, 0};
      for (int k = 0; k < 6; k++) do_instr(vecs[k], k);

      // trap entry
      poke(12'h305, 32'h1003);
      poke(12'h300, 32'h8);
      @(negedge clk);
      trap_req = 1; trap_pc = 32'h200; trap_cause = 32'h2;
      #1 chk("trap ack", {31'd0, trap_ack}, 1);
      n = 0; rpc = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         trap_req = 0;
         if (redirect_valid) begin n = i; rpc = redirect_pc; break; end
      end
      chk("trap latency", n, 5);
      chk("trap redirect_pc", rpc, 32'h1000);
      @(posedge clk); #1;
      chk("trap mepc", mem[12'h341], 32'h200);
      chk("trap mcause", mem[12'h342], 32'h2);
      chk("trap mstatus", mem[12'h300], 32'h80);
      chk("trap idle", {31'd0, busy}, 0);

      // trap and instruction together
      poke(12'h305, 32'h2000);
      poke(12'h300, 32'h8);
      poke(12'h340, 32'h10);
      @(negedge clk);
      trap_req = 1; trap_pc = 32'h300; trap_cause = 32'h3;
      instr_valid = 1; instr_op = 2'b01; instr_addr = 12'h340;
      instr_src = 32'h1; instr_nowr = 0;
      n = 0; m = 0; rd = 0;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk); #1;
         trap_req = 0;
         if (redirect_valid) n = i;
         if (instr_done) begin m = i; rd = instr_rdata; break; end
      end
      instr_valid = 0;
      chk("prio redirect", n, 5);
      chk("prio done", m, 8);
      chk("prio rdata", rd, 32'h10);
      @(posedge clk); #1;
      chk("prio csr", mem[12'h340], 32'h11);

      // mret
      poke(12'h300, 32'h80);
      poke(12'h341, 32'h204);
      @(negedge clk);
      mret_req = 1;
      n = 0; rpc = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (redirect_valid) begin n = i; rpc = redirect_pc; break; end
      end
      mret_req = 0;
      chk("mret latency", n, 3);
      chk("mret redirect_pc", rpc, 32'h204);
      @(posedge clk); #1;
      chk("mret mstatus", mem[12'h300], 32'h88);

      // rdy_in stall in I_RD
      poke(12'h340, 32'h3);
      @(negedge clk);
      instr_valid = 1; instr_op = 2'b01; instr_addr = 12'h340;
      instr_src = 32'h4; instr_nowr = 0;
      @(posedge clk); #1;
      rdy_in = 0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("stall busy", {31'd0, busy}, 1);
      chk("stall re", {31'd0, csr_re}, 0);
      chk("stall done", {31'd0, instr_done}, 0);
      rdy_in = 1;
      n = 0;
      for (int i = 5; i <= 25; i++) begin
         @(posedge clk); #1;
         if (instr_done) begin n = i; break; end
      end
      instr_valid = 0;
      chk("stall latency", n, 5);
      chk("stall rdata", instr_rdata, 32'h3);
      @(posedge clk); #1;
      chk("stall csr", mem[12'h340], 32'h7);

      // reset during T_CAUSE
      poke(12'h342, 32'h77);
      @(negedge clk);
      trap_req = 1; trap_pc = 32'h400; trap_cause = 32'h9;
      repeat (3) begin
         @(posedge clk); #1;
         trap_req = 0;
      end
      chk("abort in cause", {20'd0, csr_waddr}, 32'h342);
      rst_in = 0;
      #1;
      chk("abort busy", {31'd0, busy}, 0);
      chk("abort we", {31'd0, csr_we}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_in = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("abort mcause", mem[12'h342], 32'h77);
      chk("abort idle", {31'd0, busy}, 0);

      chk("we_re exclusive", ovl, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
